// File: rtl/mic_pdm_capture_ctrl_if.sv
// PCM output handshake bundle between the capture controller and the PCM buffer.
//   pcm       : decimated sample word (count of ones over one decimation window)
//   pcm_valid : pcm holds an unconsumed word
//   pcm_ready : consumer accepts the word when pcm_valid && pcm_ready
// master = producer (capture controller), slave = consumer.
interface mic_pdm_capture_ctrl_if #(
    parameter int unsigned PCM_W = 7
) ();
    logic [PCM_W-1:0] pcm;
    logic             pcm_valid;
    logic             pcm_ready;

    modport master (output pcm, output pcm_valid, input pcm_ready);
    modport slave  (input pcm, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/mic_pdm_capture_ctrl.sv
// PDM microphone capture controller: divides clk down to the mic bit clock,
// discards the mic warm-up period, counts ones over DEC bits per PCM word and
// offers each word through a single-entry valid/ready output register.
// Ports:
//   clk, reset      : system clock, asynchronous active-low reset
//   enable          : 1 = capture, 0 = stop at the next falling mic_clk edge
//   half_period     : mic_clk half-period in clk cycles minus 1 (latched on start)
//   mic_data        : PDM bit from the mic (asynchronous)
//   mic_clk         : bit clock to the mic
//   overrun         : sticky, a completed word was dropped
//   busy            : controller is not idle
//   pcm_if          : pcm / pcm_valid / pcm_ready output handshake
module mic_pdm_capture_ctrl #(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DEC        = 64,
    parameter int unsigned PCM_W      = 7,
    parameter int unsigned WARMUP_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [DIV_W-1:0]       half_period,
    input  logic                   mic_data,
    output logic                   mic_clk,
    output logic                   overrun,
    output logic                   busy,
    mic_pdm_capture_ctrl_if.master pcm_if
);
    localparam int unsigned WARM_W = $clog2(WARMUP_CYC + 1);
    localparam int unsigned BIT_W  = (DEC > 1) ? $clog2(DEC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_STOP} state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  hp_lat, hp_lat_nxt;
    logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
    logic [WARM_W-1:0] warm_cnt, warm_cnt_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [PCM_W-1:0]  acc, acc_nxt;
    logic [PCM_W-1:0]  pcm_nxt;
    logic              mic_clk_nxt, pcm_valid_nxt, overrun_nxt, busy_nxt;
    logic              sync1, sync2;
    logic              tick_c, strobe_c, word_done_c;
    logic [PCM_W-1:0]  word_c;

    // Two-flop synchronizer for the asynchronous PDM data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= mic_data;
            sync2 <= sync1;
        end
    end

    // Next-state, divider, decimation and output-register logic.
    always_comb begin
        state_nxt     = state;
        hp_lat_nxt    = hp_lat;
        div_cnt_nxt   = div_cnt;
        warm_cnt_nxt  = warm_cnt;
        bit_cnt_nxt   = bit_cnt;
        acc_nxt       = acc;
        mic_clk_nxt   = mic_clk;
        pcm_nxt       = pcm_if.pcm;
        pcm_valid_nxt = pcm_if.pcm_valid;
        overrun_nxt   = overrun;
        word_done_c   = 1'b0;
        tick_c        = (div_cnt == '0);
        // Divider expiring while mic_clk is high is the falling edge: sample point.
        strobe_c      = tick_c && mic_clk;
        word_c        = acc + PCM_W'(sync2);

        if (state != S_IDLE) begin
            if (tick_c) begin
                div_cnt_nxt = hp_lat;
                mic_clk_nxt = ~mic_clk;
            end else begin
                div_cnt_nxt = div_cnt - DIV_W'(1);
            end
        end

        case (state)
            S_IDLE: begin
                mic_clk_nxt = 1'b0;
                if (enable) begin
                    hp_lat_nxt   = half_period;
                    div_cnt_nxt  = half_period;
                    overrun_nxt  = 1'b0;
                    warm_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                    acc_nxt      = '0;
                    state_nxt    = S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (!enable) begin
                    state_nxt = S_STOP;
                end else if (strobe_c) begin
                    if (warm_cnt == WARM_W'(WARMUP_CYC - 1)) begin
                        acc_nxt     = '0;
                        bit_cnt_nxt = '0;
                        state_nxt   = S_RUN;
                    end else begin
                        warm_cnt_nxt = warm_cnt + WARM_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_nxt = S_STOP;
                end else if (strobe_c) begin
                    if (bit_cnt == BIT_W'(DEC - 1)) begin
                        // Word completes with this bit; next word starts with no gap.
                        word_done_c = 1'b1;
                        acc_nxt     = '0;
                        bit_cnt_nxt = '0;
                    end else begin
                        acc_nxt     = word_c;
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                // Finish the current mic_clk period low, drop any partial word.
                if (strobe_c) begin
                    mic_clk_nxt = 1'b0;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Single-entry output register: a held unaccepted word wins over a new one.
        if (word_done_c) begin
            if (!pcm_if.pcm_valid || pcm_if.pcm_ready) begin
                pcm_nxt       = word_c;
                pcm_valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (pcm_if.pcm_valid && pcm_if.pcm_ready) begin
            pcm_valid_nxt = 1'b0;
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            hp_lat           <= '0;
            div_cnt          <= '0;
            warm_cnt         <= '0;
            bit_cnt          <= '0;
            acc              <= '0;
            mic_clk          <= 1'b0;
            pcm_if.pcm       <= '0;
            pcm_if.pcm_valid <= 1'b0;
            overrun          <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_nxt;
            hp_lat           <= hp_lat_nxt;
            div_cnt          <= div_cnt_nxt;
            warm_cnt         <= warm_cnt_nxt;
            bit_cnt          <= bit_cnt_nxt;
            acc              <= acc_nxt;
            mic_clk          <= mic_clk_nxt;
            pcm_if.pcm       <= pcm_nxt;
            pcm_if.pcm_valid <= pcm_valid_nxt;
            overrun          <= overrun_nxt;
            busy             <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_mic_pdm_capture_ctrl.sv
// Self-checking bench for mic_pdm_capture_ctrl: a mic model drives PDM bits,
// a reference model predicts delivered words, and a monitor scoreboards them.
`timescale 1ns/1ps
module tb_mic_pdm_capture_ctrl;
    localparam int unsigned DIV_W      = 16;
    localparam int unsigned DEC        = 64;
    localparam int unsigned PCM_W      = 7;
    localparam int unsigned WARMUP_CYC = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [DIV_W-1:0] half_period;
    logic             mic_data;
    logic             mic_clk;
    logic             overrun;
    logic             busy;

    mic_pdm_capture_ctrl_if #(.PCM_W(PCM_W)) pcm_if ();

    mic_pdm_capture_ctrl #(
        .DIV_W(DIV_W), .DEC(DEC), .PCM_W(PCM_W), .WARMUP_CYC(WARMUP_CYC)
    ) dut (
        .clk(clk), .reset(rst_n), .enable(enable), .half_period(half_period),
        .mic_data(mic_data), .mic_clk(mic_clk), .overrun(overrun), .busy(busy),
        .pcm_if(pcm_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Mic model: new bit after each rising mic_clk, per pattern mode.
    // mode 0 = zeros, 1 = ones, 2 = alternating, 3 = random
    int mode = 0;
    bit cur_bit = 1'b0;
    bit alt_bit = 1'b0;
    bit mc_d = 1'b0;
    always begin
        @(posedge clk);
        #2;
        if (mic_clk && !mc_d) begin
            case (mode)
                0: cur_bit = 1'b0;
                1: cur_bit = 1'b1;
                2: begin alt_bit = ~alt_bit; cur_bit = alt_bit; end
                default: cur_bit = 1'($urandom_range(0, 1));
            endcase
            mic_data = cur_bit;
        end
        mc_d = mic_clk;
    end

    // Reference model: counts falling mic_clk edges since start, drops the
    // warm-up bits, popcounts each DEC-bit window and applies the one-entry
    // output register rules to decide which words get delivered.
    int exp_q[$];
    bit bits_q[$];
    int m_nbits = 0;
    int n_done  = 0;
    int nfall   = 0;
    bit cap     = 1'b0;
    bit mc_last = 1'b0;
    bit m_valid = 1'b0;
    bit m_over  = 1'b0;
    always begin
        bit fell, done, rdy;
        int w;
        @(posedge clk);
        #1;
        done = 1'b0;
        w    = 0;
        rdy  = pcm_if.pcm_ready;
        if (!rst_n) begin
            cap = 1'b0; mc_last = 1'b0; nfall = 0;
            bits_q.delete(); exp_q.delete();
            m_valid = 1'b0; m_over = 1'b0;
        end else begin
            fell    = mc_last && !mic_clk;
            mc_last = mic_clk;
            if (!enable) begin
                cap = 1'b0; nfall = 0; bits_q.delete();
            end else if (!cap) begin
                cap = 1'b1; nfall = 0; bits_q.delete(); m_over = 1'b0;
            end else if (fell) begin
                nfall++;
                if (nfall > int'(WARMUP_CYC)) begin
                    bits_q.push_back(cur_bit);
                    if (bits_q.size() == int'(DEC)) begin
                        foreach (bits_q[i]) w += int'(bits_q[i]);
                        bits_q.delete();
                        done = 1'b1;
                        n_done++;
                    end
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    exp_q.push_back(w);
                    m_valid = 1'b1;
                end else begin
                    m_over = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        m_nbits = bits_q.size();
    end

    // Monitor: output flags against the model, delivered words against the queue.
    bit chk_en   = 1'b0;
    bit hold_prev = 1'b0;
    int held     = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pcm_valid", int'(pcm_if.pcm_valid), int'(m_valid));
            chk("overrun", int'(overrun), int'(m_over));
            if (hold_prev) chk("pcm_stable", int'(pcm_if.pcm), held);
            if (pcm_if.pcm_valid && pcm_if.pcm_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", int'(pcm_if.pcm), -1);
                else chk("pcm_word", int'(pcm_if.pcm), exp_q.pop_front());
            end
            hold_prev = pcm_if.pcm_valid && !pcm_if.pcm_ready;
            held      = int'(pcm_if.pcm);
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        while (mic_clk !== lvl && n < 100) begin tick(); n++; end
    endtask

    task automatic stop_drain();
        int n;
        enable = 1'b0;
        pcm_if.pcm_ready = 1'b1;
        n = 0;
        while (busy && n < 1000) begin tick(); n++; end
        chk("stop_to_idle", int'(busy), 0);
        repeat (3) tick();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_words(input int md, input int hp, input int nw, input bit rnd_rdy);
        int target;
        mode = md;
        half_period = DIV_W'(hp);
        pcm_if.pcm_ready = 1'b1;
        enable = 1'b1;
        target = n_done + nw;
        for (int i = 0; i < 20000 && n_done < target; i++) begin
            tick();
            if (rnd_rdy) pcm_if.pcm_ready = ($urandom_range(0, 3) != 0);
        end
        chk("words_completed", n_done, target);
        stop_drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        bit saw_valid, mc_any, mc_t;
        rst_n = 1'b0; enable = 1'b0; mic_data = 1'b0; half_period = '0;
        pcm_if.pcm_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Idle after reset: everything low and static.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mic_clk || busy || overrun || pcm_if.pcm_valid || pcm_if.pcm != '0) bad = 1;
        end
        chk("reset_idle", bad, 0);
        chk_en = 1'b1;

        // Divider with half_period=2; a change while busy must be ignored.
        half_period = DIV_W'(2);
        enable = 1'b1;
        tick();
        half_period = DIV_W'(7);
        chk("busy_on_start", int'(busy), 1);
        wait_level(1'b1, n); chk("first_rise_hp2", n, 3);
        wait_level(1'b0, n); chk("high_hp2", n, 3);
        wait_level(1'b1, n); chk("low_hp2", n, 3);
        wait_level(1'b0, n); chk("high2_hp2", n, 3);
        stop_drain();

        // Divider with half_period=0: toggle every clk.
        half_period = '0;
        enable = 1'b1;
        tick();
        wait_level(1'b1, n); chk("first_rise_hp0", n, 1);
        wait_level(1'b0, n); chk("high_hp0", n, 1);
        wait_level(1'b1, n); chk("low_hp0", n, 1);
        stop_drain();

        // Decimation patterns.
        run_words(1, 2, 2, 1'b0);
        run_words(0, 2, 2, 1'b0);
        run_words(2, 3, 2, 1'b0);
        run_words(3, int'($urandom_range(2, 3)), 4, 1'b1);

        // Backpressure: two completions with ready low -> overrun, first word kept.
        mode = 3; half_period = DIV_W'(2); pcm_if.pcm_ready = 1'b0; enable = 1'b1;
        n = 0;
        while (!m_over && n < 3000) begin tick(); n++; end
        chk("overrun_set", int'(overrun), 1);
        chk("held_valid", int'(pcm_if.pcm_valid), 1);
        pcm_if.pcm_ready = 1'b1;
        tick();
        pcm_if.pcm_ready = 1'b0;
        chk("valid_fall_after_accept", int'(pcm_if.pcm_valid), 0);
        n = 0;
        while (!m_valid && n < 3000) begin tick(); n++; end
        chk("next_word_held", int'(pcm_if.pcm_valid), 1);
        // Raise ready exactly on the edge where the next word completes.
        mc_t = mic_clk;
        n = 0;
        while (!(m_nbits == int'(DEC) - 1 && mic_clk && !mc_t) && n < 3000) begin
            mc_t = mic_clk; tick(); n++;
        end
        chk("found_last_bit", m_nbits, int'(DEC) - 1);
        tick(); tick();
        pcm_if.pcm_ready = 1'b1;
        n = n_done;
        tick();
        pcm_if.pcm_ready = 1'b0;
        chk("same_cycle_word_done", n_done, n + 1);
        chk("same_cycle_valid", int'(pcm_if.pcm_valid), 1);
        enable = 1'b0;
        n = 0;
        while (busy && n < 1000) begin tick(); n++; end
        chk("held_after_stop", int'(pcm_if.pcm_valid), 1);
        chk("overrun_sticky", int'(overrun), 1);
        stop_drain();

        // Stop mid-word after 20 RUN bits.
        mode = 1; half_period = DIV_W'(2); pcm_if.pcm_ready = 1'b1; enable = 1'b1;
        tick();
        chk("restart_clears_overrun", int'(overrun), 0);
        saw_valid = 1'b0;
        n = 0;
        while (m_nbits != 20 && n < 3000) begin
            tick(); n++;
            if (pcm_if.pcm_valid) saw_valid = 1'b1;
        end
        enable = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            tick(); n++;
            if (pcm_if.pcm_valid) saw_valid = 1'b1;
        end
        chk("stop_latency", n, 6);
        mc_any = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mic_clk) mc_any = 1'b1;
            if (pcm_if.pcm_valid) saw_valid = 1'b1;
        end
        chk("mic_clk_low_after_stop", int'(mc_any), 0);
        chk("no_partial_word", int'(saw_valid), 0);

        // Asynchronous reset while running with a held word and mic_clk high.
        mode = 1; half_period = DIV_W'(2); pcm_if.pcm_ready = 1'b0; enable = 1'b1;
        n = 0;
        while (!m_valid && n < 3000) begin tick(); n++; end
        n = 0;
        while (!mic_clk && n < 20) begin tick(); n++; end
        chk("pre_reset_valid", int'(pcm_if.pcm_valid), 1);
        chk("pre_reset_mic_clk", int'(mic_clk), 1);
        chk_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_pcm_valid", int'(pcm_if.pcm_valid), 0);
        chk("rst_pcm", int'(pcm_if.pcm), 0);
        chk("rst_mic_clk", int'(mic_clk), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        tick(); tick();
        enable = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
